// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter sharing one memory slave, alternating priority.
// Optional stall watchdog compiled in with WB_ARB_TIMEOUT_EN.
module wb_mem_arbiter #(
    parameter int unsigned dw             = 32,
    parameter int unsigned aw             = 32,
    parameter int unsigned timeout_cycles = 256
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [aw-1:0]   m0_adr_i,
    input  logic [dw-1:0]   m0_dat_i,
    input  logic [dw/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic [2:0]      m0_cti_i,
    input  logic [1:0]      m0_bte_i,
    output logic [dw-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_rty_o,
    input  logic [aw-1:0]   m1_adr_i,
    input  logic [dw-1:0]   m1_dat_i,
    input  logic [dw/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic [2:0]      m1_cti_i,
    input  logic [1:0]      m1_bte_i,
    output logic [dw-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_rty_o,
    output logic [aw-1:0]   s_adr_o,
    output logic [dw-1:0]   s_dat_o,
    output logic [dw/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic [2:0]      s_cti_o,
    output logic [1:0]      s_bte_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    input  logic [dw-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic            s_rty_i,
    output logic [1:0]      grant_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e state_q;
    logic   last_m1_q;
    logic   stb_raw;
    logic   to_hit;

    // Ownership FSM; re-arbitration happens only from IDLE.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            last_m1_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || last_m1_q)) begin
                        state_q   <= OWN0;
                        last_m1_q <= 1'b0;
                    end else if (m1_cyc_i) begin
                        state_q   <= OWN1;
                        last_m1_q <= 1'b1;
                    end
                end
                OWN0:    if (!m0_cyc_i) state_q <= IDLE;
                OWN1:    if (!m1_cyc_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_o  = {state_q == OWN1, state_q == OWN0};
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign stb_raw  = (state_q == OWN0) ? m0_stb_i :
                      (state_q == OWN1) ? m1_stb_i : 1'b0;
    assign s_stb_o  = stb_raw & ~to_hit;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CW = 16;

    logic [CW-1:0] to_cnt_q;
    logic          stalled;

    assign stalled = stb_raw & ~(s_ack_i | s_err_i | s_rty_i);
    assign to_hit  = stb_raw && (to_cnt_q == CW'(timeout_cycles - 1));

    // Counts consecutive unterminated strobe cycles of the current owner.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !stalled || to_hit) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + CW'(1);
        end
    end
`else
    logic [15:0] unused_timeout;

    assign unused_timeout = 16'(timeout_cycles);
    assign to_hit         = 1'b0;
`endif

    // Owner's request drives the slave; only the owner sees terminations.
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cti_o  = 3'b000;
        s_bte_o  = 2'b00;
        s_cyc_o  = 1'b0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_rty_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_rty_o = 1'b0;
        case (state_q)
            OWN0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cti_o  = m0_cti_i;
                s_bte_o  = m0_bte_i;
                s_cyc_o  = m0_cyc_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | to_hit;
                m0_rty_o = s_rty_i;
            end
            OWN1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cti_o  = m1_cti_i;
                s_bte_o  = m1_bte_i;
                s_cyc_o  = m1_cyc_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | to_hit;
                m1_rty_o = s_rty_i;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/wb_mem_arbiter.md
WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

Interface
REQ-001 Parameter dw, default 32, data width in bits, multiple of 8.
REQ-002 Parameter aw, default 32, address width in bits.
REQ-003 Parameter timeout_cycles, default 256, stalled-strobe cycles before forced error; range 2..65535.
REQ-004 wb_clk_i  in  1  single clock, all logic on rising edge.
REQ-005 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-006 m0_adr_i/m0_dat_i/m0_sel_i  in  aw/dw/dw/8  master 0 address, write data, byte selects.
REQ-007 m0_we_i/m0_cyc_i/m0_stb_i  in  1 each  master 0 write enable, cycle, strobe.
REQ-008 m0_cti_i/m0_bte_i  in  3/2  master 0 cycle type and burst type.
REQ-009 m0_dat_o  out  dw  read data to master 0.
REQ-010 m0_ack_o/m0_err_o/m0_rty_o  out  1 each  terminations to master 0.
REQ-011 m1_* ports SHALL mirror REQ-006..REQ-010 exactly, for master 1.
REQ-012 s_adr_o/s_dat_o/s_sel_o/s_we_o/s_cti_o/s_bte_o/s_cyc_o/s_stb_o  out  aw/dw/dw/8/1/3/2/1/1  shared slave (memory) request.
REQ-013 s_dat_i/s_ack_i/s_err_i/s_rty_i  in  dw/1/1/1  slave response.
REQ-014 grant_o  out  2  one-hot current owner (bit0 = m0, bit1 = m1); 00 when idle.

Function
REQ-015 FSM states SHALL be IDLE, OWN0, OWN1; state is registered.
REQ-016 IDLE: s_cyc_o = s_stb_o = 0, all master ack/err/rty = 0, grant_o = 00.
REQ-017 IDLE with exactly one mi_cyc_i high SHALL move to OWNi at the next edge (one-cycle arbitration latency).
REQ-018 IDLE with both cyc high SHALL grant the master not granted last; after reset m0 has priority.
REQ-019 OWNi: s_* request outputs SHALL combinationally equal master i inputs; mi_ack/err/rty_o SHALL equal s_ack/err/rty_i.
REQ-020 Non-owner terminations SHALL be 0 in all states; both mi_dat_o SHALL always equal s_dat_i.
REQ-021 Ownership SHALL be held for the whole cycle, including bursts (cti 001/010) and cyc-high stb-low gaps.
REQ-022 OWNi with mi_cyc_i low SHALL return to IDLE at the next edge; s_cyc_o is 0 in that cycle.
REQ-023 Re-arbitration SHALL occur only from IDLE; no back-to-back grant without one IDLE cycle.
REQ-024 last-grant register SHALL update on every IDLE->OWNi transition.
REQ-025 Requests from the non-owner SHALL be held pending, never dropped, and never terminated.

Reset
REQ-026 wb_rst_i high at an edge SHALL force IDLE, last-grant = m1 (so m0 wins next), timeout counter = 0.
REQ-027 Reset mid-cycle SHALL drop s_cyc_o/s_stb_o and all terminations to 0 from the following cycle; in-flight transfer is abandoned.

Configuration
REQ-028 Macro WB_ARB_TIMEOUT_EN SHALL compile in a stall watchdog; without it, no counter exists and an unresponsive slave holds the owner forever.
REQ-029 With macro: counter increments each OWN cycle with s_stb_o high and s_ack_i/s_err_i/s_rty_i all low; clears on any termination, on stb low, or on leaving OWN.
REQ-030 With macro: counter reaching timeout_cycles-1 SHALL assert mi_err_o to the owner for one cycle, mask s_stb_o that cycle, and clear the counter.

Verification
REQ-031 m0 single write adr 0x10 dat 0xDEADBEEF sel 1111 from IDLE -> grant_o = 01 next cycle, s_* match m0, m0_ack_o follows s_ack_i, m1 terminations 0.
REQ-032 m0 and m1 raise cyc same cycle after reset -> m0 served first; m1 granted after one IDLE cycle; next simultaneous request -> m1 first.
REQ-033 m1 4-beat incrementing burst (cti 010, bte 00, adr 0x20) while m0 requests -> all 4 beats to m1 uninterrupted, m0 granted only after m1 cyc drops.
REQ-034 Reset asserted on beat 2 of an m0 burst -> next cycle grant_o = 00, s_cyc_o = 0; after release m0 re-requests and is granted.
REQ-035 WB_ARB_TIMEOUT_EN, timeout_cycles = 8, slave never acks -> owner sees err exactly 8 cycles after stb rises; undefined build -> no err ever.
